// File: rtl/regfile_wb_arbiter.sv
// Write-port arbiter for the RV32IM 32x32 register file: pipeline writeback vs. FIFO-buffered
// MUL/DIV results, with a pending-destination scoreboard. Optional feature macro: WB_BYPASS_EN.
`timescale 1ns/1ps
module regfile_wb_arbiter #(
    parameter int MD_FIFO_DEPTH = 2,
    parameter int STARVE_LIMIT  = 4
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        PIPE_WB_EN,
    input  logic [4:0]  PIPE_WB_ADDRESS,
    input  logic [31:0] PIPE_WB_DATA,
    input  logic        MD_ISSUE,
    input  logic [4:0]  MD_ISSUE_ADDRESS,
    input  logic        MD_VALID,
    output logic        MD_READY,
    input  logic [4:0]  MD_ADDRESS,
    input  logic [31:0] MD_DATA,
    input  logic [4:0]  CHK_ADRS1,
    input  logic [4:0]  CHK_ADRS2,
    output logic        HAZARD_STALL,
    output logic        PIPE_HOLD,
    output logic        RF_WRITE_ENABLE,
    output logic [4:0]  RF_WB_ADDRESS,
    output logic [31:0] RF_WRITE_DATA
);

    localparam int PW = $clog2(MD_FIFO_DEPTH);
    localparam int CW = $clog2(MD_FIFO_DEPTH + 1);
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    logic [4:0]    r_fifoAddr [MD_FIFO_DEPTH];
    logic [31:0]   r_fifoData [MD_FIFO_DEPTH];
    logic [PW-1:0] r_wrPtr;
    logic [PW-1:0] r_rdPtr;
    logic [CW-1:0] r_count;
    logic [31:0]   r_pending;
    logic [SW-1:0] r_starve;
    logic          r_hold;

    logic          w_fifoEmpty;
    logic          w_accept;
    logic          w_mdNonZero;
    logic          w_pipeGrant;
    logic          w_pop;
    logic          w_push;
    logic          w_bypass;
    logic          w_starved;
    logic          w_starveHit;
    logic [SW-1:0] w_starveInc;
    logic          w_mdWrite;
    logic [4:0]    w_mdWriteAddr;
    logic [31:0]   w_setMask;
    logic [31:0]   w_clrMask;
    logic [31:0]   w_pendingNext;

    assign MD_READY    = (r_count != CW'(MD_FIFO_DEPTH));
    assign w_fifoEmpty = (r_count == '0);
    assign w_accept    = MD_VALID && MD_READY;
    assign w_mdNonZero = (MD_ADDRESS != 5'd0);

    // Grants are gated by RESET so the register file sees no write while reset is asserted.
    assign w_pipeGrant = RESET && PIPE_WB_EN && (PIPE_WB_ADDRESS != 5'd0);
    assign w_pop       = RESET && !w_pipeGrant && !w_fifoEmpty;
`ifdef WB_BYPASS_EN
    assign w_bypass    = RESET && !w_pipeGrant && w_fifoEmpty && w_accept && w_mdNonZero;
`else
    assign w_bypass    = 1'b0;
`endif
    assign w_push      = w_accept && w_mdNonZero && !w_bypass;

    always_comb begin
        RF_WRITE_ENABLE = 1'b0;
        RF_WB_ADDRESS   = 5'd0;
        RF_WRITE_DATA   = 32'd0;
        if (w_pipeGrant) begin
            RF_WRITE_ENABLE = 1'b1;
            RF_WB_ADDRESS   = PIPE_WB_ADDRESS;
            RF_WRITE_DATA   = PIPE_WB_DATA;
        end else if (w_pop) begin
            RF_WRITE_ENABLE = 1'b1;
            RF_WB_ADDRESS   = r_fifoAddr[r_rdPtr];
            RF_WRITE_DATA   = r_fifoData[r_rdPtr];
        end else if (w_bypass) begin
            RF_WRITE_ENABLE = 1'b1;
            RF_WB_ADDRESS   = MD_ADDRESS;
            RF_WRITE_DATA   = MD_DATA;
        end
    end

    // Result storage carries no reset; validity is tracked by the count and pointers alone.
    always_ff @(posedge CLK) begin
        if (w_push) begin
            r_fifoAddr[r_wrPtr] <= MD_ADDRESS;
            r_fifoData[r_wrPtr] <= MD_DATA;
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wrPtr <= r_wrPtr + PW'(1);
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + PW'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CW'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - CW'(1);
            end
        end
    end

    assign w_mdWrite     = w_pop || w_bypass;
    assign w_mdWriteAddr = w_pop ? r_fifoAddr[r_rdPtr] : MD_ADDRESS;
    assign w_setMask     = (MD_ISSUE && MD_ISSUE_ADDRESS != 5'd0) ? (32'd1 << MD_ISSUE_ADDRESS) : 32'd0;
    assign w_clrMask     = w_mdWrite ? (32'd1 << w_mdWriteAddr) : 32'd0;
    // Clear is applied before set so a same-cycle re-issue keeps the register pending.
    assign w_pendingNext = ((r_pending & ~w_clrMask) | w_setMask) & ~32'd1;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_pending <= 32'd0;
        end else begin
            r_pending <= w_pendingNext;
        end
    end

    assign HAZARD_STALL = (CHK_ADRS1 != 5'd0 && r_pending[CHK_ADRS1])
                        | (CHK_ADRS2 != 5'd0 && r_pending[CHK_ADRS2])
                        | (MD_ISSUE && r_pending[MD_ISSUE_ADDRESS]);

    assign w_starved   = w_pipeGrant && !w_fifoEmpty;
    assign w_starveInc = r_starve + SW'(1);
    assign w_starveHit = w_starved && (w_starveInc == SW'(STARVE_LIMIT));

    // Reaching the limit requests a one-cycle writeback bubble so the FIFO head can drain.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_starve <= '0;
            r_hold   <= 1'b0;
        end else begin
            r_hold <= w_starveHit;
            if (w_pop || w_starveHit) begin
                r_starve <= '0;
            end else if (w_starved) begin
                r_starve <= w_starveInc;
            end
        end
    end

    assign PIPE_HOLD = r_hold;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed scenarios plus a randomized run
// checked against a queue-based reference model.
`timescale 1ns/1ps
module tb_regfile_wb_arbiter;

    localparam int DEPTH = 2;
    localparam int LIMIT = 4;
`ifdef WB_BYPASS_EN
    localparam logic BYP = 1'b1;
`else
    localparam logic BYP = 1'b0;
`endif

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        PIPE_WB_EN;
    logic [4:0]  PIPE_WB_ADDRESS;
    logic [31:0] PIPE_WB_DATA;
    logic        MD_ISSUE;
    logic [4:0]  MD_ISSUE_ADDRESS;
    logic        MD_VALID;
    logic        MD_READY;
    logic [4:0]  MD_ADDRESS;
    logic [31:0] MD_DATA;
    logic [4:0]  CHK_ADRS1;
    logic [4:0]  CHK_ADRS2;
    logic        HAZARD_STALL;
    logic        PIPE_HOLD;
    logic        RF_WRITE_ENABLE;
    logic [4:0]  RF_WB_ADDRESS;
    logic [31:0] RF_WRITE_DATA;

    int nChecks = 0;
    int nPass = 0;

    regfile_wb_arbiter #(.MD_FIFO_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
        .CLK(CLK), .RESET(RESET),
        .PIPE_WB_EN(PIPE_WB_EN), .PIPE_WB_ADDRESS(PIPE_WB_ADDRESS), .PIPE_WB_DATA(PIPE_WB_DATA),
        .MD_ISSUE(MD_ISSUE), .MD_ISSUE_ADDRESS(MD_ISSUE_ADDRESS),
        .MD_VALID(MD_VALID), .MD_READY(MD_READY), .MD_ADDRESS(MD_ADDRESS), .MD_DATA(MD_DATA),
        .CHK_ADRS1(CHK_ADRS1), .CHK_ADRS2(CHK_ADRS2),
        .HAZARD_STALL(HAZARD_STALL), .PIPE_HOLD(PIPE_HOLD),
        .RF_WRITE_ENABLE(RF_WRITE_ENABLE), .RF_WB_ADDRESS(RF_WB_ADDRESS), .RF_WRITE_DATA(RF_WRITE_DATA)
    );

    always #5 CLK = ~CLK;

    task automatic idle();
        PIPE_WB_EN = 1'b0; PIPE_WB_ADDRESS = 5'd0; PIPE_WB_DATA = 32'd0;
        MD_ISSUE = 1'b0; MD_ISSUE_ADDRESS = 5'd0;
        MD_VALID = 1'b0; MD_ADDRESS = 5'd0; MD_DATA = 32'd0;
        CHK_ADRS1 = 5'd0; CHK_ADRS2 = 5'd0;
    endtask

    task automatic nextCycle();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        idle();
        RESET = 1'b0;
        PIPE_WB_EN = 1'b1; PIPE_WB_ADDRESS = 5'd3; PIPE_WB_DATA = 32'h55; CHK_ADRS1 = 5'd5;
        nextCycle();
        #1;
        nChecks++; if (RF_WRITE_ENABLE !== 1'b0) $display("[TB] FAIL reset_we: got %b want 0", RF_WRITE_ENABLE); else nPass++;
        nChecks++; if (RF_WB_ADDRESS !== 5'd0) $display("[TB] FAIL reset_addr: got %0d want 0", RF_WB_ADDRESS); else nPass++;
        nChecks++; if (MD_READY !== 1'b1) $display("[TB] FAIL reset_ready: got %b want 1", MD_READY); else nPass++;
        nChecks++; if (HAZARD_STALL !== 1'b0) $display("[TB] FAIL reset_stall: got %b want 0", HAZARD_STALL); else nPass++;
        nChecks++; if (PIPE_HOLD !== 1'b0) $display("[TB] FAIL reset_hold: got %b want 0", PIPE_HOLD); else nPass++;
        idle();
        RESET = 1'b1;
    endtask

    task automatic test_contention();
        for (int c = 0; c < 5; c++) begin
            nextCycle();
            idle();
            MD_ISSUE = (c == 0); MD_ISSUE_ADDRESS = 5'd7;
            CHK_ADRS1 = (c == 0) ? 5'd0 : 5'd7;
            if (c == 2) begin
                PIPE_WB_EN = 1'b1; PIPE_WB_ADDRESS = 5'd3; PIPE_WB_DATA = 32'h11;
                MD_VALID = 1'b1; MD_ADDRESS = 5'd7; MD_DATA = 32'h22;
            end
            #1;
            if (c == 1 || c == 3) begin
                nChecks++; if (HAZARD_STALL !== 1'b1) $display("[TB] FAIL contention_stall c%0d: got %b want 1", c, HAZARD_STALL); else nPass++;
            end
            if (c == 2) begin
                nChecks++; if ({RF_WRITE_ENABLE, RF_WB_ADDRESS, RF_WRITE_DATA} !== {1'b1, 5'd3, 32'h11})
                    $display("[TB] FAIL contention_pipe: got we=%b a=%0d d=%h want we=1 a=3 d=11", RF_WRITE_ENABLE, RF_WB_ADDRESS, RF_WRITE_DATA); else nPass++;
            end
            if (c == 3) begin
                nChecks++; if ({RF_WRITE_ENABLE, RF_WB_ADDRESS, RF_WRITE_DATA} !== {1'b1, 5'd7, 32'h22})
                    $display("[TB] FAIL contention_md: got we=%b a=%0d d=%h want we=1 a=7 d=22", RF_WRITE_ENABLE, RF_WB_ADDRESS, RF_WRITE_DATA); else nPass++;
            end
            if (c == 4) begin
                nChecks++; if (HAZARD_STALL !== 1'b0) $display("[TB] FAIL contention_clear: got %b want 0", HAZARD_STALL); else nPass++;
                nChecks++; if (RF_WRITE_ENABLE !== 1'b0) $display("[TB] FAIL contention_idle_we: got %b want 0", RF_WRITE_ENABLE); else nPass++;
            end
        end
    endtask

    task automatic test_full_fifo();
        for (int c = 0; c < 10; c++) begin
            nextCycle();
            idle();
            PIPE_WB_EN = (c <= 6 && c != 5); PIPE_WB_ADDRESS = 5'd1; PIPE_WB_DATA = 32'h100 + 32'(c);
            MD_VALID = (c <= 6);
            MD_ADDRESS = (c == 0) ? 5'd10 : (c == 1) ? 5'd11 : 5'd12;
            MD_DATA = 32'hA0 + 32'(MD_ADDRESS);
            #1;
            if (c == 0 || c == 1 || c == 6) begin
                nChecks++; if (MD_READY !== 1'b1) $display("[TB] FAIL full_ready c%0d: got %b want 1", c, MD_READY); else nPass++;
            end
            if (c >= 2 && c <= 5) begin
                nChecks++; if (MD_READY !== 1'b0) $display("[TB] FAIL full_ready c%0d: got %b want 0", c, MD_READY); else nPass++;
            end
            if (c == 5) begin
                nChecks++; if (PIPE_HOLD !== 1'b1) $display("[TB] FAIL full_hold: got %b want 1", PIPE_HOLD); else nPass++;
                nChecks++; if ({RF_WRITE_ENABLE, RF_WB_ADDRESS, RF_WRITE_DATA} !== {1'b1, 5'd10, 32'hAA})
                    $display("[TB] FAIL full_pop10: got we=%b a=%0d d=%h want we=1 a=10 d=aa", RF_WRITE_ENABLE, RF_WB_ADDRESS, RF_WRITE_DATA); else nPass++;
            end
            if (c == 7) begin
                nChecks++; if ({RF_WRITE_ENABLE, RF_WB_ADDRESS, RF_WRITE_DATA} !== {1'b1, 5'd11, 32'hAB})
                    $display("[TB] FAIL full_pop11: got we=%b a=%0d d=%h want we=1 a=11 d=ab", RF_WRITE_ENABLE, RF_WB_ADDRESS, RF_WRITE_DATA); else nPass++;
            end
            if (c == 8) begin
                nChecks++; if ({RF_WRITE_ENABLE, RF_WB_ADDRESS, RF_WRITE_DATA} !== {1'b1, 5'd12, 32'hAC})
                    $display("[TB] FAIL full_pop12: got we=%b a=%0d d=%h want we=1 a=12 d=ac", RF_WRITE_ENABLE, RF_WB_ADDRESS, RF_WRITE_DATA); else nPass++;
            end
            if (c == 9) begin
                nChecks++; if (RF_WRITE_ENABLE !== 1'b0) $display("[TB] FAIL full_drained: got %b want 0", RF_WRITE_ENABLE); else nPass++;
            end
        end
    endtask

    task automatic test_starvation();
        for (int c = 0; c < 7; c++) begin
            nextCycle();
            idle();
            PIPE_WB_EN = (c <= 4); PIPE_WB_ADDRESS = 5'd2; PIPE_WB_DATA = 32'h200 + 32'(c);
            MD_VALID = (c == 0); MD_ADDRESS = 5'd13; MD_DATA = 32'h33;
            #1;
            if (c >= 1 && c <= 4) begin
                nChecks++; if (PIPE_HOLD !== 1'b0) $display("[TB] FAIL starve_nohold c%0d: got %b want 0", c, PIPE_HOLD); else nPass++;
                nChecks++; if (RF_WB_ADDRESS !== 5'd2) $display("[TB] FAIL starve_pipe c%0d: got %0d want 2", c, RF_WB_ADDRESS); else nPass++;
            end
            if (c == 5) begin
                nChecks++; if (PIPE_HOLD !== 1'b1) $display("[TB] FAIL starve_hold: got %b want 1", PIPE_HOLD); else nPass++;
                nChecks++; if ({RF_WRITE_ENABLE, RF_WB_ADDRESS, RF_WRITE_DATA} !== {1'b1, 5'd13, 32'h33})
                    $display("[TB] FAIL starve_drain: got we=%b a=%0d d=%h want we=1 a=13 d=33", RF_WRITE_ENABLE, RF_WB_ADDRESS, RF_WRITE_DATA); else nPass++;
            end
            if (c == 6) begin
                nChecks++; if ({PIPE_HOLD, RF_WRITE_ENABLE} !== 2'b00) $display("[TB] FAIL starve_after: got hold=%b we=%b want 0 0", PIPE_HOLD, RF_WRITE_ENABLE); else nPass++;
            end
        end
    endtask

    task automatic test_scoreboard();
        logic expStall [11];
        expStall = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        for (int c = 0; c < 11; c++) begin
            nextCycle();
            idle();
            MD_ISSUE = (c == 0 || c == 1 || c == 4 || c == 6); MD_ISSUE_ADDRESS = 5'd9;
            CHK_ADRS1 = (c == 1) ? 5'd0 : (c == 10) ? 5'd3 : 5'd9;
            if (c == 2 || c == 5 || c == 7) begin
                PIPE_WB_EN = 1'b1; PIPE_WB_ADDRESS = 5'd1; PIPE_WB_DATA = 32'h1;
                MD_VALID = 1'b1; MD_ADDRESS = 5'd9; MD_DATA = 32'h90 + 32'(c);
            end
            #1;
            nChecks++; if (HAZARD_STALL !== expStall[c]) $display("[TB] FAIL sb_stall c%0d: got %b want %b", c, HAZARD_STALL, expStall[c]); else nPass++;
            if (c == 3 || c == 6 || c == 8) begin
                nChecks++; if ({RF_WRITE_ENABLE, RF_WB_ADDRESS, RF_WRITE_DATA} !== {1'b1, 5'd9, 32'h90 + 32'(c - 1)})
                    $display("[TB] FAIL sb_write c%0d: got we=%b a=%0d d=%h want we=1 a=9 d=%h", c, RF_WRITE_ENABLE, RF_WB_ADDRESS, RF_WRITE_DATA, 32'h90 + 32'(c - 1)); else nPass++;
            end
        end
    endtask

    task automatic test_bypass();
        for (int c = 0; c < 3; c++) begin
            nextCycle();
            idle();
            MD_VALID = (c == 0); MD_ADDRESS = 5'd4; MD_DATA = 32'hDEAD;
            #1;
            if (c == 0) begin
                nChecks++; if (RF_WRITE_ENABLE !== BYP) $display("[TB] FAIL bypass_c0_we: got %b want %b", RF_WRITE_ENABLE, BYP); else nPass++;
            end
            if (c == 1) begin
                nChecks++; if (RF_WRITE_ENABLE !== !BYP) $display("[TB] FAIL bypass_c1_we: got %b want %b", RF_WRITE_ENABLE, !BYP); else nPass++;
                nChecks++; if (MD_READY !== 1'b1) $display("[TB] FAIL bypass_ready: got %b want 1", MD_READY); else nPass++;
            end
            if ((c == 0 && BYP) || (c == 1 && !BYP)) begin
                nChecks++; if ({RF_WB_ADDRESS, RF_WRITE_DATA} !== {5'd4, 32'hDEAD})
                    $display("[TB] FAIL bypass_data c%0d: got a=%0d d=%h want a=4 d=dead", c, RF_WB_ADDRESS, RF_WRITE_DATA); else nPass++;
            end
            if (c == 2) begin
                nChecks++; if (RF_WRITE_ENABLE !== 1'b0) $display("[TB] FAIL bypass_done: got %b want 0", RF_WRITE_ENABLE); else nPass++;
            end
        end
    endtask

    task automatic test_reset_drop();
        for (int c = 0; c < 4; c++) begin
            nextCycle();
            idle();
            MD_ISSUE = (c == 0); MD_ISSUE_ADDRESS = 5'd5;
            CHK_ADRS1 = 5'd5;
            PIPE_WB_EN = (c >= 1); PIPE_WB_ADDRESS = 5'd1; PIPE_WB_DATA = 32'h1;
            MD_VALID = (c == 1 || c == 2); MD_ADDRESS = (c == 1) ? 5'd5 : 5'd6; MD_DATA = 32'h5555;
        end
        #1;
        nChecks++; if ({MD_READY, HAZARD_STALL} !== 2'b01) $display("[TB] FAIL drop_pre: got rdy=%b stall=%b want 0 1", MD_READY, HAZARD_STALL); else nPass++;
        RESET = 1'b0;
        #1;
        nChecks++; if ({RF_WRITE_ENABLE, MD_READY, HAZARD_STALL} !== 3'b010)
            $display("[TB] FAIL drop_now: got we=%b rdy=%b stall=%b want 0 1 0", RF_WRITE_ENABLE, MD_READY, HAZARD_STALL); else nPass++;
        nextCycle();
        idle();
        RESET = 1'b1;
        CHK_ADRS1 = 5'd5;
        for (int c = 0; c < 3; c++) begin
            nextCycle();
            #1;
            nChecks++; if ({RF_WRITE_ENABLE, HAZARD_STALL} !== 2'b00) $display("[TB] FAIL drop_after c%0d: got we=%b stall=%b want 0 0", c, RF_WRITE_ENABLE, HAZARD_STALL); else nPass++;
        end
    endtask

    task automatic test_random();
        logic [36:0] mq[$];
        logic [31:0] mPend;
        int          mDenied;
        logic        mHold, nextHold, accept, pipeWins, popped, bypassed, starved;
        logic        expReady, expWe, expStall;
        logic [4:0]  expAddr;
        logic [31:0] expData;
        logic [40:0] act, exp;
        nextCycle();
        idle();
        RESET = 1'b0;
        nextCycle();
        RESET = 1'b1;
        mPend = 32'd0; mDenied = 0; mHold = 1'b0;
        for (int n = 0; n < 1500; n++) begin
            nextCycle();
            idle();
            PIPE_WB_EN = !mHold && ($urandom_range(0, 99) < 55);
            PIPE_WB_ADDRESS = 5'($urandom_range(0, 7));
            PIPE_WB_DATA = $urandom;
            MD_ISSUE = ($urandom_range(0, 99) < 30);
            MD_ISSUE_ADDRESS = 5'($urandom_range(0, 7));
            MD_VALID = ($urandom_range(0, 99) < 50);
            MD_ADDRESS = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(8, 31)) : 5'($urandom_range(0, 7));
            MD_DATA = $urandom;
            CHK_ADRS1 = 5'($urandom_range(0, 7));
            CHK_ADRS2 = 5'($urandom_range(0, 7));
            #1;
            expReady = (mq.size() < DEPTH);
            accept   = MD_VALID && expReady;
            pipeWins = PIPE_WB_EN && (PIPE_WB_ADDRESS != 5'd0);
            expWe = 1'b0; expAddr = 5'd0; expData = 32'd0; popped = 1'b0; bypassed = 1'b0;
            if (pipeWins) begin
                expWe = 1'b1; expAddr = PIPE_WB_ADDRESS; expData = PIPE_WB_DATA;
            end else if (mq.size() > 0) begin
                expWe = 1'b1; expAddr = mq[0][36:32]; expData = mq[0][31:0]; popped = 1'b1;
            end else if (BYP && accept && MD_ADDRESS != 5'd0) begin
                expWe = 1'b1; expAddr = MD_ADDRESS; expData = MD_DATA; bypassed = 1'b1;
            end
            expStall = (CHK_ADRS1 != 5'd0 && mPend[CHK_ADRS1]) || (CHK_ADRS2 != 5'd0 && mPend[CHK_ADRS2])
                     || (MD_ISSUE && mPend[MD_ISSUE_ADDRESS]);
            exp = {expWe, expAddr, expData, expReady, expStall, mHold};
            act = {RF_WRITE_ENABLE, RF_WB_ADDRESS, RF_WRITE_DATA, MD_READY, HAZARD_STALL, PIPE_HOLD};
            nChecks++;
            if (act !== exp)
                $display("[TB] FAIL random cycle %0d: got we=%b a=%0d d=%h rdy=%b stall=%b hold=%b want we=%b a=%0d d=%h rdy=%b stall=%b hold=%b",
                         n, RF_WRITE_ENABLE, RF_WB_ADDRESS, RF_WRITE_DATA, MD_READY, HAZARD_STALL, PIPE_HOLD,
                         expWe, expAddr, expData, expReady, expStall, mHold);
            else nPass++;
            starved = (mq.size() > 0) && pipeWins;
            if (popped) begin
                mPend[expAddr] = 1'b0;
                void'(mq.pop_front());
            end
            if (bypassed) mPend[MD_ADDRESS] = 1'b0;
            if (accept && MD_ADDRESS != 5'd0 && !bypassed) mq.push_back({MD_ADDRESS, MD_DATA});
            if (MD_ISSUE && MD_ISSUE_ADDRESS != 5'd0) mPend[MD_ISSUE_ADDRESS] = 1'b1;
            nextHold = 1'b0;
            if (starved) begin
                mDenied++;
                if (mDenied == LIMIT) begin
                    nextHold = 1'b1;
                    mDenied = 0;
                end
            end else if (popped) begin
                mDenied = 0;
            end
            mHold = nextHold;
        end
    endtask

    initial begin
        test_reset();
        test_contention();
        test_full_fifo();
        test_starvation();
        test_scoreboard();
        test_bypass();
        test_reset_drop();
        test_random();
        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
